// File: rtl/fpu_host_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_host_if
// Brief    : Responder end of the FPU 8-bit host bus. Captures operands and
//            the opcode byte-wise, launches the arithmetic core, latches its
//            result and holds cmd_end until the host acknowledges.
// Options  : FPU_TIMEOUT_EN - WAIT-state watchdog; on expiry the result is
//            forced to qNaN and the status timeout bit is set.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_host_if #(
    parameter int OP_W           = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            arst,
    input  logic [7:0]      databus_in,
    output logic [7:0]      databus_out,
    input  logic [3:0]      addr,
    input  logic            cs,
    input  logic            rd,
    input  logic            wr,
    input  logic            end_ack,
    output logic            cmd_end,
    output logic            busy,
    output logic [31:0]     operand_a,
    output logic [31:0]     operand_b,
    output logic [OP_W-1:0] operation,
    output logic            start,
    input  logic            core_done,
    input  logic [31:0]     core_result
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ACK   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               wr_q;
    logic [31:0]        opa_q, opa_d;
    logic [31:0]        opb_q, opb_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [31:0]        res_q, res_d;

    logic               w_commit;
    logic               w_timeout;
    logic [7:0]         w_rd_data;
    logic [7:0]         w_op_byte;

`ifdef FPU_TIMEOUT_EN
    localparam int          CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;

    assign w_timeout = timeout_q;
`else
    // Watchdog absent: the limit is carried only so both builds share one
    // parameter list.
    logic               w_timeout_param_unused;
    assign w_timeout_param_unused = (TIMEOUT_CYCLES > 0);
    assign w_timeout = 1'b0;
`endif

    // Falling edge of wr while selected: exactly one commit per wr pulse.
    assign w_commit = ~cs & ~wr & wr_q;

    assign operand_a = opa_q;
    assign operand_b = opb_q;
    assign operation = op_q;

    // State, strobe history and register file.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= S_IDLE;
            wr_q      <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            op_q      <= '0;
            res_q     <= '0;
`ifdef FPU_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_q      <= wr;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            op_q      <= op_d;
            res_q     <= res_d;
`ifdef FPU_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Next state, register updates and handshake outputs. Host writes are
    // only honoured in IDLE so the core sees stable operands.
    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        op_d      = op_q;
        res_d     = res_q;
        start     = 1'b0;
        busy      = 1'b0;
        cmd_end   = 1'b0;
`ifdef FPU_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_commit) begin
                    case (addr)
                        4'h0, 4'h1, 4'h2, 4'h3: opa_d[8*addr[1:0] +: 8] = databus_in;
                        4'h4, 4'h5, 4'h6, 4'h7: opb_d[8*addr[1:0] +: 8] = databus_in;
                        4'h8: begin
                            op_d    = databus_in[OP_W-1:0];
                            state_d = S_START;
`ifdef FPU_TIMEOUT_EN
                            timeout_d = 1'b0;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            S_START: begin
                start   = 1'b1;
                busy    = 1'b1;
                state_d = S_WAIT;
`ifdef FPU_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                busy = 1'b1;
                if (core_done) begin
                    res_d   = core_result;
                    state_d = S_DONE;
                end
`ifdef FPU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    res_d     = C_QNAN;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                cmd_end = 1'b1;
                if (end_ack) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!end_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read mux: combinational, side-effect free, driven only during a read.
    always_comb begin
        w_op_byte             = '0;
        w_op_byte[OP_W-1:0]   = op_q;
        w_rd_data             = 8'h00;
        case (addr)
            4'h0, 4'h1, 4'h2, 4'h3: w_rd_data = opa_q[8*addr[1:0] +: 8];
            4'h4, 4'h5, 4'h6, 4'h7: w_rd_data = opb_q[8*addr[1:0] +: 8];
            4'h8:                   w_rd_data = w_op_byte;
            4'h9:                   w_rd_data = res_q[7:0];
            4'hA:                   w_rd_data = res_q[15:8];
            4'hB:                   w_rd_data = res_q[23:16];
            4'hC:                   w_rd_data = res_q[31:24];
            4'hD:                   w_rd_data = {5'b0, w_timeout, cmd_end, busy};
            default:                w_rd_data = 8'h00;
        endcase
        databus_out = (!cs && !rd) ? w_rd_data : 8'h00;
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_host_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_host_if
// Brief    : Self-checking bench for fpu_host_if with a transaction-level
//            reference model and a stub arithmetic core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_host_if;
`ifdef FPU_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif
    localparam int OP_W = 4;

    logic            clk = 1'b0;
    logic            arst = 1'b1;
    logic [7:0]      databus_in = 8'h00;
    logic [7:0]      databus_out;
    logic [3:0]      addr = 4'h0;
    logic            cs = 1'b1;
    logic            rd = 1'b1;
    logic            wr = 1'b1;
    logic            end_ack = 1'b0;
    logic            cmd_end;
    logic            busy;
    logic [31:0]     operand_a;
    logic [31:0]     operand_b;
    logic [OP_W-1:0] operation;
    logic            start;
    logic            core_done;
    logic [31:0]     core_result;

    int checks = 0;
    int errors = 0;

    fpu_host_if #(.OP_W(OP_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .arst(arst),
        .databus_in(databus_in), .databus_out(databus_out),
        .addr(addr), .cs(cs), .rd(rd), .wr(wr),
        .end_ack(end_ack), .cmd_end(cmd_end), .busy(busy),
        .operand_a(operand_a), .operand_b(operand_b), .operation(operation),
        .start(start), .core_done(core_done), .core_result(core_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] m_opa = '0, m_opb = '0, m_res = '0;
    int          m_op = 0;
    bit          m_start = 0, m_wait = 0, m_done = 0, m_hold = 0, m_to = 0, m_wrq = 0;
    int          m_wcnt = 0;

    function automatic logic [7:0] m_read(input logic [3:0] a);
        int i;
        i = int'(a);
        if (i < 4)   return 8'(m_opa >> (8 * i));
        if (i < 8)   return 8'(m_opb >> (8 * (i - 4)));
        if (i == 8)  return 8'(m_op);
        if (i < 13)  return 8'(m_res >> (8 * (i - 9)));
        if (i == 13) return {5'b0, m_to, m_done, (m_start || m_wait)};
        return 8'h00;
    endfunction

    task automatic model_step();
        bit idle, commit;
        int i;
        if (arst) begin
            m_opa = '0; m_opb = '0; m_res = '0; m_op = 0;
            m_start = 0; m_wait = 0; m_done = 0; m_hold = 0; m_to = 0; m_wrq = 0;
            m_wcnt = 0;
            return;
        end
        idle   = !(m_start || m_wait || m_done || m_hold);
        commit = (cs == 1'b0) && (wr == 1'b0) && m_wrq;
        i      = int'(addr);
        if (m_start) begin
            m_start = 0; m_wait = 1; m_wcnt = 0;
        end else if (m_wait) begin
            m_wcnt++;
            if (core_done) begin
                m_res = core_result; m_wait = 0; m_done = 1;
            end
`ifdef FPU_TIMEOUT_EN
            else if (m_wcnt == TO) begin
                m_res = 32'h7FC00000; m_to = 1; m_wait = 0; m_done = 1;
            end
`endif
        end else if (m_done) begin
            if (end_ack) begin m_done = 0; m_hold = 1; end
        end else if (m_hold) begin
            if (!end_ack) m_hold = 0;
        end
        if (idle && commit) begin
            if (i < 4)
                m_opa = (m_opa & ~(32'hFF << (8 * i))) | (32'(databus_in) << (8 * i));
            else if (i < 8)
                m_opb = (m_opb & ~(32'hFF << (8 * (i - 4)))) | (32'(databus_in) << (8 * (i - 4)));
            else if (i == 8) begin
                m_op = int'(databus_in) % (1 << OP_W);
                m_start = 1; m_to = 0;
            end
        end
        m_wrq = wr;
    endtask

    initial forever begin
        @(posedge clk or posedge arst);
        model_step();
    end

    // Every cycle, away from the active edge, the DUT must match the model.
    initial forever begin
        @(negedge clk);
        chk("busy", 32'(busy), 32'(m_start || m_wait));
        chk("start", 32'(start), 32'(m_start));
        chk("cmd_end", 32'(cmd_end), 32'(m_done));
        chk("operand_a", operand_a, m_opa);
        chk("operand_b", operand_b, m_opb);
        chk("operation", 32'(operation), 32'(m_op));
        chk("databus_out", 32'(databus_out), 32'((cs == 1'b0 && rd == 1'b0) ? m_read(addr) : 8'h00));
    end

    // ---------------- stub arithmetic core ----------------
    bit          stub_en = 0;
    int          stub_delay = 10;
    logic [31:0] stub_val = '0;
    int          start_seen = 0;
    int          fire_cnt = 0;

    initial begin : stub
        int cnt;
        int fire_done;
        cnt = 0; fire_done = 0;
        core_done = 1'b0; core_result = '0;
        forever begin
            @(posedge clk); #1;
            core_done = 1'b0;
            if (start === 1'b1) begin
                start_seen++;
                if (stub_en) cnt = stub_delay;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin core_done = 1'b1; core_result = stub_val; end
            end
            if (fire_cnt != fire_done) begin
                fire_done = fire_cnt;
                core_done = 1'b1; core_result = 32'hDEADBEEF;
            end
        end
    end

    // ---------------- bus tasks ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // wr held low for two edges: still exactly one commit.
    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        cs = 1'b0; addr = a; databus_in = d; wr = 1'b0;
        cyc(); cyc();
        wr = 1'b1; cs = 1'b1;
        cyc();
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
        cs = 1'b0; rd = 1'b0; addr = a;
        #2;
        chk(name, 32'(databus_out), 32'(exp));
        cyc();
        cs = 1'b1; rd = 1'b1;
    endtask

    task automatic wait_cmd_end(input int maxc);
        int n;
        n = 0;
        while (cmd_end !== 1'b1 && n < maxc) begin cyc(); n++; end
        chk("cmd_end_wait", 32'(cmd_end), 32'd1);
    endtask

    task automatic ack();
        end_ack = 1'b1; cyc();
        chk("cmd_end_fall", 32'(cmd_end), 32'd0);
        end_ack = 1'b0; cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int s0;
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;
        cyc();

        // Reset state
        rd_chk("status_after_reset", 4'hD, 8'h00);
        chk("opa_after_reset", operand_a, 32'h0);

        // Operand writes
        bus_write(4'h0, 8'h64); bus_write(4'h1, 8'hAB);
        bus_write(4'h2, 8'hA9); bus_write(4'h3, 8'h43);
        bus_write(4'h4, 8'h64); bus_write(4'h5, 8'hAB);
        bus_write(4'h6, 8'hA9); bus_write(4'h7, 8'h43);
        chk("operand_a_val", operand_a, 32'h43A9AB64);
        chk("operand_b_val", operand_b, 32'h43A9AB64);
        rd_chk("read_a3", 4'h3, 8'h43);
        rd_chk("read_b0", 4'h4, 8'h64);

        // Full operation
        stub_en = 1; stub_delay = 10; stub_val = 32'h47E0E7A5;
        s0 = start_seen;
        bus_write(4'h8, 8'h02);
        chk("operation_val", 32'(operation), 32'h2);
        wait_cmd_end(40);
        chk("one_start_pulse", 32'(start_seen - s0), 32'd1);
        rd_chk("res_b0", 4'h9, 8'hA5);
        rd_chk("res_b1", 4'hA, 8'hE7);
        rd_chk("res_b2", 4'hB, 8'hE0);
        rd_chk("res_b3", 4'hC, 8'h47);
        rd_chk("status_done", 4'hD, 8'h02);
        rd_chk("read_op", 4'h8, 8'h02);
        end_ack = 1'b1; cyc();
        chk("cmd_end_fall_ack", 32'(cmd_end), 32'd0);

        // Handshake order: end_ack still high, opcode write must be ignored
        s0 = start_seen;
        bus_write(4'h8, 8'h07);
        chk("op_ignored_ack_high", 32'(operation), 32'h2);
        chk("no_start_ack_high", 32'(start_seen - s0), 32'd0);
        end_ack = 1'b0; cyc();
        stub_delay = 12; stub_val = 32'h12345678;
        s0 = start_seen;
        bus_write(4'h8, 8'h03);
        chk("op_accepted", 32'(operation), 32'h3);

        // Busy lockout while in WAIT
        bus_write(4'h0, 8'hFF);
        bus_write(4'h8, 8'h05);
        chk("lockout_opa", operand_a, 32'h43A9AB64);
        chk("lockout_op", 32'(operation), 32'h3);
        chk("lockout_start", 32'(start_seen - s0), 32'd1);
        wait_cmd_end(60);
        rd_chk("res2_b0", 4'h9, 8'h78);
        ack();

        // Reset held mid-WAIT
        stub_en = 0;
        bus_write(4'h8, 8'h01);
        chk("busy_in_wait", 32'(busy), 32'd1);
        arst = 1'b1;
        #500;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_cmd_end", 32'(cmd_end), 32'd0);
        chk("rst_opa", operand_a, 32'h0);
        chk("rst_op", 32'(operation), 32'h0);
        arst = 1'b0;
        cyc(); cyc();
        rd_chk("status_post_rst", 4'hD, 8'h00);
        fire_cnt++;
        repeat (3) cyc();
        chk("late_done_ignored", 32'(cmd_end), 32'd0);
        rd_chk("res_cleared", 4'h9, 8'h00);

        // Simultaneous read and write of the same register
        cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 4'h0; databus_in = 8'h5A;
        #2;
        chk("rw_pre_value", 32'(databus_out), 32'h00);
        cyc();
        chk("rw_post_value", 32'(databus_out), 32'h5A);
        wr = 1'b1; rd = 1'b1; cs = 1'b1;
        cyc();

        // Writes above 0x8 are ignored; unmapped reads return 0
        bus_write(4'hC, 8'h99);
        rd_chk("ignored_write_c", 4'hC, 8'h00);
        rd_chk("read_e", 4'hE, 8'h00);

`ifdef FPU_TIMEOUT_EN
        // Watchdog: core never answers
        bus_write(4'h8, 8'h01);
        wait_cmd_end(40);
        rd_chk("to_b0", 4'h9, 8'h00);
        rd_chk("to_b1", 4'hA, 8'h00);
        rd_chk("to_b2", 4'hB, 8'hC0);
        rd_chk("to_b3", 4'hC, 8'h7F);
        rd_chk("to_status", 4'hD, 8'h06);
        ack();
`endif

        repeat (2) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
